// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// reset level, operation codes, FSM state encoding and op decode helpers.
package ex_muldiv_pkg;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one step per cycle, on magnitudes loaded by ex_muldiv.
module muldiv_core
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               last_o
);

  // acc_q holds {hi, lo}: multiply = {partial sum, remaining multiplier},
  // divide = {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // Only the low bits are kept: when the subtract succeeds the remainder fits WIDTH bits.
    rem_diff  = rem_shift[WIDTH-1:0] - b_q;
    acc_next  = '0;
    if (is_div) begin
      if (rem_shift >= {1'b0, b_q}) begin
        acc_next = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= {{WIDTH{1'b0}}, a_mag};
      b_q   <= b_mag;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign acc_o  = acc_q;
  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit: FSM, sign handling,
// divide-by-zero shortcut and ready/stall handshake around muldiv_core.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               divzero_o,
  output logic               stallreq_o
);

  state_e             state_q, state_d;
  op_e                op_in;
  logic               accept;
  logic               in_signed, a_neg, b_neg, dz_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_q, sa_q, sb_q, dz_q;
  logic [2*WIDTH-1:0] res_q, hold_q, fix_val;
  logic [2*WIDTH-1:0] core_acc;
  logic [CNT_W-1:0]   core_cnt;
  logic               core_last, core_step;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    op_in     = op_e'(op_i);
    accept    = (state_q == S_IDLE) & start_i & ~annul_i;
    in_signed = op_is_signed(op_in);
    a_neg     = in_signed & opdata1_i[WIDTH-1];
    b_neg     = in_signed & opdata2_i[WIDTH-1];
    a_mag     = a_neg ? -opdata1_i : opdata1_i;
    b_mag     = b_neg ? -opdata2_i : opdata2_i;
    dz_in     = op_is_div(op_in) & (opdata2_i == '0);
    core_step = (state_q == S_CALC) & ~annul_i;
  end

  muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (core_step),
    .is_div (div_q),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc_o  (core_acc),
    .cnt_o  (core_cnt),
    .last_o (core_last)
  );

  // Sign flags are only latched for signed ops, so unsigned ops never negate.
  always_comb begin
    quo     = core_acc[WIDTH-1:0];
    rem     = core_acc[2*WIDTH-1:WIDTH];
    fix_val = core_acc;
    if (div_q) begin
      fix_val = {(sa_q ? -rem : rem), ((sa_q ^ sb_q) ? -quo : quo)};
    end else if (sa_q ^ sb_q) begin
      fix_val = -core_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = dz_in ? S_DONE : S_CALC;
      S_CALC: begin
        if (annul_i)        state_d = S_IDLE;
        else if (core_last) state_d = S_FIX;
      end
      S_FIX:   state_d = annul_i ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      div_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      res_q  <= '0;
      hold_q <= '0;
    end else begin
      if (accept) begin
        div_q <= op_is_div(op_in);
        sa_q  <= a_neg;
        sb_q  <= b_neg;
        dz_q  <= dz_in;
        if (dz_in) res_q <= {opdata1_i, {WIDTH{1'b1}}};
      end
      if ((state_q == S_FIX) && !annul_i) res_q <= fix_val;
      if (ready_o) hold_q <= res_q;
    end
  end

  // The new result is only visible in the delivering cycle, so an annulled
  // DONE leaves result_o at the previously delivered value.
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    ready_o    = (state_q == S_DONE) & ~annul_i;
    divzero_o  = ready_o & dz_q;
    stallreq_o = (start_i & (state_q == S_IDLE) & ~annul_i) | (busy_o & ~ready_o);
    result_o   = ready_o ? res_q : hold_q;
  end

endmodule
